// File: rtl/branch_hazard_ctrl_if.sv
// Control bundle between the ID-stage branch resolution sequencer and the rest
// of the pipeline: hazard inputs, redirect request, PC/IF/ID controls, counters.
interface branch_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             ext_stall;
    logic             id_valid;
    logic [5:0]       id_opcode;
    logic [4:0]       id_rs;
    logic [4:0]       ex_rd;
    logic             ex_regwrite;
    logic             ex_memread;
    logic [4:0]       mem_rd;
    logic             mem_regwrite;
    logic             mem_memread;
    logic             take_branch;
    logic [31:0]      branch_target;
    logic [31:0]      pc_plus_four;
    logic [31:0]      next_pc;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] taken_count;
    logic [CNT_W-1:0] stall_count;

    // Pipeline side: drives the ID/EX/MEM state, observes the controls.
    modport master (
        output ext_stall, id_valid, id_opcode, id_rs,
        output ex_rd, ex_regwrite, ex_memread,
        output mem_rd, mem_regwrite, mem_memread,
        output take_branch, branch_target, pc_plus_four,
        input  next_pc, pc_write, if_id_write, if_id_flush, id_ex_bubble,
        input  branch_count, taken_count, stall_count
    );

    // Sequencer side.
    modport slave (
        input  ext_stall, id_valid, id_opcode, id_rs,
        input  ex_rd, ex_regwrite, ex_memread,
        input  mem_rd, mem_regwrite, mem_memread,
        input  take_branch, branch_target, pc_plus_four,
        output next_pc, pc_write, if_id_write, if_id_flush, id_ex_bubble,
        output branch_count, taken_count, stall_count
    );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// ID-stage jump/branch sequencer for the 5-stage DLX pipeline.
// Stalls IF/ID while the branch source register is still in flight, issues
// PC redirects for taken branches/jumps, flushes wrong-path fetches and keeps
// branch/stall performance counters.
module branch_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_hazard_ctrl_if.slave  bus
);

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_JR   = 6'h12;
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_BNEZ = 6'h05;

    // The redirect cycle itself is the first flush cycle, so FLUSH covers the rest.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        FLUSH
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       cnt;
    logic [2:0]       cnt_next;

    logic             is_branch;
    logic             is_reader;
    logic [1:0]       need;
    logic             redirect;

    logic             inc_branch;
    logic             inc_taken;
    logic             inc_stall;

    logic [CNT_W-1:0] branch_count_q;
    logic [CNT_W-1:0] taken_count_q;
    logic [CNT_W-1:0] stall_count_q;

    // Classify the ID instruction; only register-reading branches can hazard.
    always_comb begin
        is_branch = 1'b0;
        is_reader = 1'b0;
        if (bus.id_valid) begin
            case (bus.id_opcode)
                OP_J, OP_JAL: begin
                    is_branch = 1'b1;
                end
                OP_JR, OP_BEQZ, OP_BNEZ: begin
                    is_branch = 1'b1;
                    is_reader = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Number of cycles rs1 is still unavailable to the ID-stage comparator.
    always_comb begin
        need = 2'd0;
        if (is_reader && (bus.id_rs != 5'd0)) begin
            if (bus.ex_regwrite && bus.ex_memread && (bus.ex_rd == bus.id_rs)) begin
                need = 2'd2;
            end else if (bus.ex_regwrite && (bus.ex_rd == bus.id_rs)) begin
                need = 2'd1;
            end else if (bus.mem_regwrite && bus.mem_memread && (bus.mem_rd == bus.id_rs)) begin
                need = 2'd1;
            end
        end
    end

    assign redirect = (state == IDLE) && (need == 2'd0) && bus.take_branch && is_branch;

    // Next state, counter increments and pipeline controls; reset forces a bubble.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        bus.next_pc      = redirect ? bus.branch_target : bus.pc_plus_four;
        bus.pc_write     = 1'b0;
        bus.if_id_write  = 1'b0;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_bubble = 1'b0;
        inc_branch       = 1'b0;
        inc_taken        = 1'b0;
        inc_stall        = 1'b0;

        if (!bus.ext_stall) begin
            case (state)
                IDLE: begin
                    if (need != 2'd0) begin
                        bus.id_ex_bubble = 1'b1;
                        inc_stall        = 1'b1;
                        cnt_next         = {1'b0, need};
                        // A one-cycle hazard is covered by this cycle alone.
                        if (need > 2'd1) begin
                            state_next = STALL;
                        end
                    end else if (redirect) begin
                        bus.pc_write    = 1'b1;
                        bus.if_id_flush = 1'b1;
                        inc_taken       = 1'b1;
                        inc_branch      = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_next = FLUSH;
                            cnt_next   = FLUSH_LOAD;
                        end
                    end else begin
                        bus.pc_write    = 1'b1;
                        bus.if_id_write = 1'b1;
                        inc_branch      = is_branch;
                    end
                end
                STALL: begin
                    bus.id_ex_bubble = 1'b1;
                    inc_stall        = 1'b1;
                    cnt_next         = cnt - 3'd1;
                    if (cnt <= 3'd2) begin
                        state_next = IDLE;
                    end
                end
                FLUSH: begin
                    bus.pc_write    = 1'b1;
                    bus.if_id_flush = 1'b1;
                    cnt_next        = cnt - 3'd1;
                    if (cnt <= 3'd1) begin
                        state_next = IDLE;
                        cnt_next   = 3'd0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                end
            endcase
        end

        if (reset) begin
            bus.next_pc      = bus.pc_plus_four;
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.if_id_flush  = 1'b1;
            bus.id_ex_bubble = 1'b1;
        end
    end

    // State register and down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Performance counters; they freeze with the pipeline and wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count_q <= '0;
            taken_count_q  <= '0;
            stall_count_q  <= '0;
        end else if (!bus.ext_stall) begin
            branch_count_q <= branch_count_q + CNT_W'(inc_branch);
            taken_count_q  <= taken_count_q + CNT_W'(inc_taken);
            stall_count_q  <= stall_count_q + CNT_W'(inc_stall);
        end
    end

    assign bus.branch_count = branch_count_q;
    assign bus.taken_count  = taken_count_q;
    assign bus.stall_count  = stall_count_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: two instances (1-cycle and 3-cycle flush) see
// identical stimulus; both are compared every cycle against a cycle-count model,
// plus a hand-written vector table and scenario sequences with fixed expectations.
module tb_branch_hazard_ctrl;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_JR   = 6'h12;
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_BNEZ = 6'h05;
    localparam logic [5:0] OP_LW   = 6'h23;

    typedef struct {
        logic        ext_stall;
        logic        id_valid;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  ex_rd;
        logic        ex_rw;
        logic        ex_mr;
        logic [4:0]  mem_rd;
        logic        mem_rw;
        logic        mem_mr;
        logic        take;
        logic [31:0] target;
        logic [31:0] pc4;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        pw;
        logic        iw;
        logic        fl;
        logic        bb;
        bit          chk_pc;
        logic [31:0] npc;
    } vec_t;

    logic  clk = 1'b0;
    logic  reset;
    stim_t cur;

    int vectors     = 0;
    int miscompares = 0;

    // Model: remaining stall/flush cycles and expected counter values per instance.
    int          flush_cycles [2] = '{1, 3};
    int          stall_left   [2];
    int          flush_left   [2];
    logic [31:0] m_branch     [2];
    logic [31:0] m_taken      [2];
    logic [31:0] m_stall      [2];

    always #5 clk = ~clk;

    branch_hazard_ctrl_if #(.CNT_W(32)) bus1 ();
    branch_hazard_ctrl_if #(.CNT_W(32)) bus3 ();

    branch_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    branch_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    function automatic stim_t mk(input logic es, input logic v, input logic [5:0] op,
                                 input logic [4:0] rs, input logic [4:0] exrd,
                                 input logic exrw, input logic exmr,
                                 input logic [4:0] mrd, input logic mrw, input logic mmr,
                                 input logic take);
        stim_t s;
        s.ext_stall = es;
        s.id_valid  = v;
        s.opcode    = op;
        s.rs        = rs;
        s.ex_rd     = exrd;
        s.ex_rw     = exrw;
        s.ex_mr     = exmr;
        s.mem_rd    = mrd;
        s.mem_rw    = mrw;
        s.mem_mr    = mmr;
        s.take      = take;
        s.target    = 32'h0000_1000;
        s.pc4       = 32'h0000_0204;
        return s;
    endfunction

    function automatic bit is_branch(input stim_t s);
        return s.id_valid && (s.opcode inside {OP_J, OP_JAL, OP_JR, OP_BEQZ, OP_BNEZ});
    endfunction

    // Cycles the branch must wait for rs1, straight from the hazard rules.
    function automatic int need_of(input stim_t s);
        bit reader;
        reader = s.id_valid && (s.opcode inside {OP_JR, OP_BEQZ, OP_BNEZ}) && (s.rs != 5'd0);
        if (!reader) return 0;
        if (s.ex_rw && s.ex_mr && (s.ex_rd == s.rs)) return 2;
        if (s.ex_rw && (s.ex_rd == s.rs)) return 1;
        if (s.mem_rw && s.mem_mr && (s.mem_rd == s.rs)) return 1;
        return 0;
    endfunction

    task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        cur = s;
        bus1.ext_stall     = s.ext_stall;  bus3.ext_stall     = s.ext_stall;
        bus1.id_valid      = s.id_valid;   bus3.id_valid      = s.id_valid;
        bus1.id_opcode     = s.opcode;     bus3.id_opcode     = s.opcode;
        bus1.id_rs         = s.rs;         bus3.id_rs         = s.rs;
        bus1.ex_rd         = s.ex_rd;      bus3.ex_rd         = s.ex_rd;
        bus1.ex_regwrite   = s.ex_rw;      bus3.ex_regwrite   = s.ex_rw;
        bus1.ex_memread    = s.ex_mr;      bus3.ex_memread    = s.ex_mr;
        bus1.mem_rd        = s.mem_rd;     bus3.mem_rd        = s.mem_rd;
        bus1.mem_regwrite  = s.mem_rw;     bus3.mem_regwrite  = s.mem_rw;
        bus1.mem_memread   = s.mem_mr;     bus3.mem_memread   = s.mem_mr;
        bus1.take_branch   = s.take;       bus3.take_branch   = s.take;
        bus1.branch_target = s.target;     bus3.branch_target = s.target;
        bus1.pc_plus_four  = s.pc4;        bus3.pc_plus_four  = s.pc4;
    endtask

    task automatic read_outputs(input int k, output logic [31:0] npc, output logic pw,
                                output logic iw, output logic fl, output logic bb,
                                output logic [31:0] bc, output logic [31:0] tc,
                                output logic [31:0] sc);
        if (k == 0) begin
            npc = bus1.next_pc; pw = bus1.pc_write; iw = bus1.if_id_write;
            fl = bus1.if_id_flush; bb = bus1.id_ex_bubble;
            bc = bus1.branch_count; tc = bus1.taken_count; sc = bus1.stall_count;
        end else begin
            npc = bus3.next_pc; pw = bus3.pc_write; iw = bus3.if_id_write;
            fl = bus3.if_id_flush; bb = bus3.id_ex_bubble;
            bc = bus3.branch_count; tc = bus3.taken_count; sc = bus3.stall_count;
        end
    endtask

    // Compare both instances with the model for this cycle, then advance the model.
    task automatic checkOutput();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] npc, bc, tc, sc, e_pc;
            logic        pw, iw, fl, bb, e_pw, e_iw, e_fl, e_bb;
            int          kind;
            int          n;
            string       tag;
            tag = (k == 0) ? "f1" : "f3";
            read_outputs(k, npc, pw, iw, fl, bb, bc, tc, sc);
            n = need_of(cur);
            // kind: 0 frozen, 1 stall, 2 flush, 3 redirect, 4 advance
            if (cur.ext_stall)                        kind = 0;
            else if (stall_left[k] > 0)               kind = 1;
            else if (flush_left[k] > 0)               kind = 2;
            else if (n > 0)                           kind = 1;
            else if (cur.take && is_branch(cur))      kind = 3;
            else                                      kind = 4;
            e_pc = (kind == 3) ? cur.target : cur.pc4;
            e_pw = (kind == 2) || (kind == 3) || (kind == 4);
            e_iw = (kind == 4);
            e_fl = (kind == 2) || (kind == 3);
            e_bb = (kind == 1);
            expectEq({tag, ".pc_write"},     pw, e_pw);
            expectEq({tag, ".if_id_write"},  iw, e_iw);
            expectEq({tag, ".if_id_flush"},  fl, e_fl);
            expectEq({tag, ".id_ex_bubble"}, bb, e_bb);
            if (kind != 0) expectEq({tag, ".next_pc"}, npc, e_pc);
            expectEq({tag, ".branch_count"}, bc, m_branch[k]);
            expectEq({tag, ".taken_count"},  tc, m_taken[k]);
            expectEq({tag, ".stall_count"},  sc, m_stall[k]);
            case (kind)
                1: begin
                    m_stall[k]++;
                    if (stall_left[k] > 0) stall_left[k]--;
                    else                   stall_left[k] = n - 1;
                end
                2: flush_left[k]--;
                3: begin
                    m_taken[k]++;
                    m_branch[k]++;
                    flush_left[k] = flush_cycles[k] - 1;
                end
                4: if (is_branch(cur)) m_branch[k]++;
                default: begin
                end
            endcase
        end
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] npc, bc, tc, sc;
            logic        pw, iw, fl, bb;
            string       tag;
            tag = (k == 0) ? "f1.rst" : "f3.rst";
            read_outputs(k, npc, pw, iw, fl, bb, bc, tc, sc);
            expectEq({tag, ".pc_write"},     pw, 1'b0);
            expectEq({tag, ".if_id_write"},  iw, 1'b0);
            expectEq({tag, ".if_id_flush"},  fl, 1'b1);
            expectEq({tag, ".id_ex_bubble"}, bb, 1'b1);
            expectEq({tag, ".next_pc"},      npc, cur.pc4);
            expectEq({tag, ".branch_count"}, bc, 32'd0);
            expectEq({tag, ".taken_count"},  tc, 32'd0);
            expectEq({tag, ".stall_count"},  sc, 32'd0);
        end
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            stall_left[k] = 0;
            flush_left[k] = 0;
            m_branch[k]   = '0;
            m_taken[k]    = '0;
            m_stall[k]    = '0;
        end
        check_reset_outputs();
        @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
    endtask

    task automatic start_cycle(input stim_t s);
        applyStimulus(s);
        #4;
        checkOutput();
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t  tbl [$];
        vec_t  v;
        stim_t s;
        stim_t idle;

        idle = mk(0, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(idle);
        do_reset();

        // Single-cycle decode cases from IDLE on the 1-cycle-flush instance.
        v.chk_pc = 1;
        v.s = mk(0, 1, OP_ADD,  7, 0, 0, 0, 0, 0, 0, 0); v.pw=1; v.iw=1; v.fl=0; v.bb=0; v.npc=32'h204;  tbl.push_back(v);
        v.s = mk(0, 1, OP_ADD,  7, 0, 0, 0, 0, 0, 0, 1); v.pw=1; v.iw=1; v.fl=0; v.bb=0; v.npc=32'h204;  tbl.push_back(v);
        v.s = mk(0, 1, OP_J,    7, 7, 1, 1, 0, 0, 0, 1); v.pw=1; v.iw=0; v.fl=1; v.bb=0; v.npc=32'h1000; tbl.push_back(v);
        v.s = mk(0, 1, OP_BEQZ, 3, 3, 1, 0, 0, 0, 0, 1); v.pw=0; v.iw=0; v.fl=0; v.bb=1; v.npc=32'h204;  tbl.push_back(v);
        v.s = mk(0, 1, OP_BEQZ, 0, 0, 1, 1, 0, 0, 0, 1); v.pw=1; v.iw=0; v.fl=1; v.bb=0; v.npc=32'h1000; tbl.push_back(v);
        v.s = mk(0, 1, OP_BNEZ, 5, 0, 0, 0, 5, 1, 1, 0); v.pw=0; v.iw=0; v.fl=0; v.bb=1; v.npc=32'h204;  tbl.push_back(v);
        v.s = mk(0, 1, OP_BNEZ, 5, 0, 0, 0, 5, 1, 0, 0); v.pw=1; v.iw=1; v.fl=0; v.bb=0; v.npc=32'h204;  tbl.push_back(v);
        v.s = mk(0, 1, OP_JR,   9, 9, 0, 1, 0, 0, 0, 1); v.pw=1; v.iw=0; v.fl=1; v.bb=0; v.npc=32'h1000; tbl.push_back(v);
        v.s = mk(0, 0, OP_JAL,  0, 0, 0, 0, 0, 0, 0, 1); v.pw=1; v.iw=1; v.fl=0; v.bb=0; v.npc=32'h204;  tbl.push_back(v);
        v.s = mk(0, 1, OP_LW,   2, 0, 0, 0, 0, 0, 0, 1); v.pw=1; v.iw=1; v.fl=0; v.bb=0; v.npc=32'h204;  tbl.push_back(v);
        v.s = mk(0, 1, OP_JAL,  4, 4, 1, 1, 0, 0, 0, 1); v.pw=1; v.iw=0; v.fl=1; v.bb=0; v.npc=32'h1000; tbl.push_back(v);
        v.chk_pc = 0;
        v.s = mk(1, 1, OP_JAL,  0, 0, 0, 0, 0, 0, 0, 1); v.pw=0; v.iw=0; v.fl=0; v.bb=0; v.npc=32'h0;    tbl.push_back(v);

        foreach (tbl[i]) begin
            start_cycle(tbl[i].s);
            expectEq($sformatf("tbl%0d.pc_write", i),     bus1.pc_write,     tbl[i].pw);
            expectEq($sformatf("tbl%0d.if_id_write", i),  bus1.if_id_write,  tbl[i].iw);
            expectEq($sformatf("tbl%0d.if_id_flush", i),  bus1.if_id_flush,  tbl[i].fl);
            expectEq($sformatf("tbl%0d.id_ex_bubble", i), bus1.id_ex_bubble, tbl[i].bb);
            if (tbl[i].chk_pc) expectEq($sformatf("tbl%0d.next_pc", i), bus1.next_pc, tbl[i].npc);
            end_cycle();
        end

        // Load-use on beqz: two stall cycles, then the redirect.
        do_reset();
        s = mk(0, 1, OP_BEQZ, 3, 3, 1, 1, 0, 0, 0, 0);
        s.target = 32'h100;
        for (int c = 0; c < 2; c++) begin
            start_cycle(s);
            expectEq("lw.stall_pc_write", bus1.pc_write, 1'b0);
            expectEq("lw.stall_bubble",   bus1.id_ex_bubble, 1'b1);
            end_cycle();
        end
        s.ex_rd = 0; s.ex_rw = 0; s.ex_mr = 0; s.take = 1;
        start_cycle(s);
        expectEq("lw.next_pc",     bus1.next_pc, 32'h100);
        expectEq("lw.flush",       bus1.if_id_flush, 1'b1);
        expectEq("lw.stall_count", bus1.stall_count, 32'd2);
        end_cycle();
        start_cycle(idle);
        expectEq("lw.flush_done",   bus1.if_id_flush, 1'b0);
        expectEq("lw.taken_count",  bus1.taken_count, 32'd1);
        expectEq("lw.branch_count", bus1.branch_count, 32'd1);
        end_cycle();

        // ALU result in EX: exactly one stall; r0 never hazards.
        do_reset();
        s = mk(0, 1, OP_BNEZ, 5, 5, 1, 0, 0, 0, 0, 0);
        start_cycle(s);
        expectEq("alu.bubble", bus1.id_ex_bubble, 1'b1);
        end_cycle();
        s.ex_rd = 0; s.ex_rw = 0; s.take = 1;
        start_cycle(s);
        expectEq("alu.next_pc",     bus1.next_pc, 32'h1000);
        expectEq("alu.stall_count", bus1.stall_count, 32'd1);
        end_cycle();
        s = mk(0, 1, OP_BEQZ, 0, 0, 1, 1, 0, 0, 0, 0);
        start_cycle(s);
        expectEq("r0.pc_write", bus1.pc_write, 1'b1);
        expectEq("r0.bubble",   bus1.id_ex_bubble, 1'b0);
        end_cycle();

        // j does not read rs1.
        do_reset();
        s = mk(0, 1, OP_J, 7, 7, 1, 1, 0, 0, 0, 1);
        start_cycle(s);
        expectEq("j.next_pc", bus1.next_pc, 32'h1000);
        expectEq("j.bubble",  bus1.id_ex_bubble, 1'b0);
        end_cycle();
        start_cycle(idle);
        expectEq("j.branch_count", bus1.branch_count, 32'd1);
        end_cycle();

        // Three-cycle flush on jal, stray take_branch during the flush ignored.
        do_reset();
        start_cycle(mk(0, 1, OP_JAL, 0, 0, 0, 0, 0, 0, 0, 1));
        expectEq("jal3.flush1", bus3.if_id_flush, 1'b1);
        expectEq("jal3.pc",     bus3.next_pc, 32'h1000);
        end_cycle();
        start_cycle(idle);
        expectEq("jal3.flush2", bus3.if_id_flush, 1'b1);
        end_cycle();
        start_cycle(mk(0, 1, OP_BEQZ, 0, 0, 0, 0, 0, 0, 0, 1));
        expectEq("jal3.flush3",    bus3.if_id_flush, 1'b1);
        expectEq("jal3.pc_ignore", bus3.next_pc, 32'h204);
        end_cycle();
        start_cycle(idle);
        expectEq("jal3.flush_end",   bus3.if_id_flush, 1'b0);
        expectEq("jal3.taken_count", bus3.taken_count, 32'd1);
        end_cycle();

        // ext_stall in the middle of a load-use stall.
        do_reset();
        s = mk(0, 1, OP_BEQZ, 3, 3, 1, 1, 0, 0, 0, 0);
        start_cycle(s);
        end_cycle();
        s.ext_stall = 1;
        for (int c = 0; c < 4; c++) begin
            start_cycle(s);
            expectEq("es.bubble",      bus1.id_ex_bubble, 1'b0);
            expectEq("es.stall_count", bus1.stall_count, 32'd1);
            end_cycle();
        end
        s.ext_stall = 0;
        start_cycle(s);
        expectEq("es.resume_bubble", bus1.id_ex_bubble, 1'b1);
        end_cycle();
        s.ex_rd = 0; s.ex_rw = 0; s.ex_mr = 0;
        start_cycle(s);
        expectEq("es.released",    bus1.pc_write, 1'b1);
        expectEq("es.stall_count", bus1.stall_count, 32'd2);
        end_cycle();

        // Reset while stalled, then confirm IDLE behaviour.
        do_reset();
        start_cycle(mk(0, 1, OP_BEQZ, 3, 3, 1, 1, 0, 0, 0, 0));
        end_cycle();
        do_reset();
        start_cycle(idle);
        expectEq("rst.idle_pc_write", bus1.pc_write, 1'b1);
        expectEq("rst.idle_if_id",    bus1.if_id_write, 1'b1);
        end_cycle();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end else begin
                s.ext_stall = ($urandom_range(0, 9) == 0);
                s.id_valid  = ($urandom_range(0, 7) != 0);
                case ($urandom_range(0, 6))
                    0: s.opcode = OP_ADD;
                    1: s.opcode = OP_J;
                    2: s.opcode = OP_JAL;
                    3: s.opcode = OP_JR;
                    4: s.opcode = OP_BEQZ;
                    5: s.opcode = OP_BNEZ;
                    default: s.opcode = OP_LW;
                endcase
                s.rs     = 5'($urandom_range(0, 3));
                s.ex_rd  = 5'($urandom_range(0, 3));
                s.ex_rw  = 1'($urandom_range(0, 1));
                s.ex_mr  = 1'($urandom_range(0, 1));
                s.mem_rd = 5'($urandom_range(0, 3));
                s.mem_rw = 1'($urandom_range(0, 1));
                s.mem_mr = 1'($urandom_range(0, 1));
                s.take   = ($urandom_range(0, 4) < 2);
                s.target = $urandom;
                s.pc4    = $urandom;
                start_cycle(s);
                end_cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Sequences the ID-stage jump/branch resolution unit in the 5-stage DLX pipeline.
- Detects data hazards on the branch source register (rs1) and stalls IF/ID until the operand is valid in the register file/forwarding path.
- Selects the redirect PC when a branch or jump is taken, flushes wrong-path fetches, and keeps branch/stall performance counters.

Parameters:
- FLUSH_CYCLES, 1, cycles if_id_flush stays asserted after a redirect (1..7; >1 for multi-cycle fetch)
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- ext_stall  in  1  global freeze from memory system
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  6  opcode of the ID instruction
- id_rs  in  5  rs field of the ID instruction
- ex_rd  in  5  destination register of the EX instruction
- ex_regwrite  in  1  EX instruction writes a register
- ex_memread  in  1  EX instruction is a load
- mem_rd  in  5  destination register of the MEM instruction
- mem_regwrite  in  1  MEM instruction writes a register
- mem_memread  in  1  MEM instruction is a load
- take_branch  in  1  resolution unit says redirect
- branch_target  in  32  resolved target PC
- pc_plus_four  in  32  sequential next PC
- next_pc  out  32  PC to load
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_bubble  out  1  load NOP into ID/EX
- branch_count  out  CNT_W  branch-class instructions retired from ID
- taken_count  out  CNT_W  redirects issued
- stall_count  out  CNT_W  hazard stall cycles

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset); its polarity and synchronicity are fixed.
- Branch class: j (0x02), jal (0x03), jr (0x12), beqz (0x04), bnez (0x05).
  - Reader class (uses rs1): jr, beqz, bnez only.
  - Branch-class decode requires id_valid=1.
- Hazard check: applies to a reader-class instruction with id_rs != 0.
  - need=2 if ex_regwrite & ex_memread & ex_rd==id_rs.
  - else need=1 if ex_regwrite & ex_rd==id_rs (ALU result not forwardable into ID).
  - else need=1 if mem_regwrite & mem_memread & mem_rd==id_rs.
  - else need=0.
- FSM states: IDLE, STALL, FLUSH. Registered state; cnt (3 bits) is a registered down-counter.
- IDLE:
  - If need>0: go to STALL with cnt=need. Assert stall outputs this cycle (first stall cycle counted).
  - Else if take_branch and branch-class: next_pc=branch_target, pc_write=1, if_id_flush=1, taken_count+1. Go to FLUSH with cnt=FLUSH_CYCLES-1, or stay in IDLE if FLUSH_CYCLES=1.
  - Else: next_pc=pc_plus_four, pc_write=1, if_id_write=1.
  - take_branch is ignored for non-branch opcodes. The branch opcode check takes priority over a stray take_branch.
- Stall outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, stall_count+1.
- STALL:
  - Stall outputs every cycle; cnt decrements.
  - When cnt reaches 1, return to IDLE next cycle and re-evaluate.
  - A residual hazard starts a new stall. take_branch is ignored in STALL.
- FLUSH:
  - Outputs: if_id_flush=1, pc_write=1, next_pc=pc_plus_four.
  - cnt decrements; go to IDLE when cnt==0.
  - take_branch is ignored (ID holds a bubble).
- branch_count increments once per branch-class instruction, on the cycle it leaves ID (IDLE, need==0). Stalled cycles do not count.
- ext_stall=1 overrides everything:
  - pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0.
  - State, cnt and counters hold.
  - A pending redirect is issued on the first cycle after ext_stall drops.
- Counters wrap modulo 2^CNT_W.
- Reset (any time, including mid-STALL/FLUSH):
  - State=IDLE, cnt=0, all counters=0.
  - While reset is high: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, next_pc=pc_plus_four.
- next_pc and the control outputs are combinational from state and inputs. Counters are registered.

Test Plan:
- beqz r3 in ID, EX holds lw r3 (ex_memread=1) -> 2 cycles of pc_write=0/id_ex_bubble=1; stall_count=2; then take_branch=1, target 0x100 -> next_pc=0x100, if_id_flush=1 for 1 cycle, taken_count=1.
- bnez r5 in ID, EX holds add r5 -> exactly 1 stall cycle, then branch resolves; beqz r0 with ex_rd=0 -> no stall.
- j with ex_rd==id_rs and ex_memread=1 -> no stall (j is not a reader); immediate redirect to branch_target; branch_count=1.
- FLUSH_CYCLES=3, jal taken -> if_id_flush high 3 consecutive cycles. A take_branch pulse during cycles 2-3 is ignored (taken_count stays 1).
- ext_stall raised during STALL cnt=2 for 4 cycles -> cnt holds, stall_count unchanged; stall resumes and completes after ext_stall drops.
- reset asserted mid-STALL -> outputs go immediately to reset values (async); after release, FSM is in IDLE and all counters=0.
